// File: rtl/ds_sample_fifo_feeder.sv
// Host-to-modulator sample feeder: captures 16-bit words from the byte-wide
// data_part handshake, buffers them, and releases one word per divider+1 pulses.
module ds_sample_fifo_feeder #(
    parameter int DEPTH       = 8,
    parameter int DIV_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               data_in,
    input  logic                     data_part_in,
    input  logic                     sel,
    input  logic                     pulse_done,
    input  logic [DIV_BITS-1:0]      divider,
    input  logic                     flush,
    input  logic                     clear_flags,
    output logic [15:0]              sample_out,
    output logic                     sample_update,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);

    // Host strobe synchronizer and edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   part_last_q;
    logic                   part_sync;
    logic                   part_fall;
    logic                   part_rise;

    logic [7:0]             data_low_q,  data_low_d;
    logic                   push_pend_q, push_pend_d;
    logic [15:0]            push_word_q, push_word_d;

    logic [AW:0]            wptr_q, wptr_d;
    logic [AW:0]            rptr_q, rptr_d;
    logic [DIV_BITS-1:0]    cnt_q,  cnt_d;
    logic [15:0]            sample_out_q, sample_out_d;
    logic                   sample_update_q, sample_update_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic [15:0]            mem [DEPTH];

    logic                   empty_w;
    logic                   full_w;
    logic                   pulse_zero;
    logic                   pop_fire;
    logic                   push_fire;
    logic                   ovf_set;
    logic                   unf_set;

    assign part_sync = sync_q[SYNC_STAGES-1];
    assign part_fall = !part_sync &&  part_last_q;
    assign part_rise =  part_sync && !part_last_q;

    // Flops reset high so a strobe already high at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            part_last_q <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], data_part_in};
            part_last_q <= part_sync;
        end
    end

    assign empty_w    = (wptr_q == rptr_q);
    assign full_w     = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    assign pulse_zero = pulse_done && (cnt_q == '0);

    // Flush overrides every same-cycle push, pop and flag event
    assign pop_fire   = pulse_zero && !empty_w && !flush;
    assign push_fire  = push_pend_q && !flush && (!full_w || pop_fire);
    assign ovf_set    = push_pend_q && !flush && full_w && !pop_fire;
    assign unf_set    = pulse_zero && empty_w && !flush;

    always_comb begin
        data_low_d      = data_low_q;
        push_pend_d     = 1'b0;
        push_word_d     = push_word_q;
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        cnt_d           = cnt_q;
        sample_out_d    = sample_out_q;
        sample_update_d = 1'b0;
        overflow_d      = (overflow_q  && !clear_flags) || ovf_set;
        underflow_d     = (underflow_q && !clear_flags) || unf_set;

        if (part_fall) begin
            data_low_d = data_in;
        end
        if (part_rise && sel) begin
            push_pend_d = 1'b1;
            push_word_d = {data_in, data_low_q};
        end

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = divider;
        end else begin
            if (push_fire) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_fire) begin
                rptr_d          = rptr_q + 1'b1;
                sample_out_d    = mem[rptr_q[AW-1:0]];
                sample_update_d = 1'b1;
            end
            if (pulse_zero) begin
                cnt_d = divider;
            end else if (pulse_done) begin
                cnt_d = cnt_q - DIV_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_low_q      <= '0;
            push_pend_q     <= 1'b0;
            push_word_q     <= '0;
            wptr_q          <= '0;
            rptr_q          <= '0;
            cnt_q           <= '0;
            sample_out_q    <= 16'h8000;
            sample_update_q <= 1'b0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            data_low_q      <= data_low_d;
            push_pend_q     <= push_pend_d;
            push_word_q     <= push_word_d;
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            cnt_q           <= cnt_d;
            sample_out_q    <= sample_out_d;
            sample_update_q <= sample_update_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    // Storage carries no reset; a write into the slot being popped reads the old word
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wptr_q[AW-1:0]] <= push_word_q;
        end
    end

    assign sample_out    = sample_out_q;
    assign sample_update = sample_update_q;
    assign level         = wptr_q - rptr_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_ds_sample_fifo_feeder.sv
// Directed bench for ds_sample_fifo_feeder; expected values are hand-derived.
module tb_ds_sample_fifo_feeder;

    localparam int DEPTH       = 8;
    localparam int DIV_BITS    = 8;
    localparam int SYNC_STAGES = 2;

    logic                   clk;
    logic                   rst_n;
    logic [7:0]             data_in;
    logic                   data_part_in;
    logic                   sel;
    logic                   pulse_done;
    logic [DIV_BITS-1:0]    divider;
    logic                   flush;
    logic                   clear_flags;
    logic [15:0]            sample_out;
    logic                   sample_update;
    logic [$clog2(DEPTH):0] level;
    logic                   full;
    logic                   empty;
    logic                   overflow;
    logic                   underflow;

    int n_assert = 0;
    int n_fail   = 0;
    int n_upd;

    ds_sample_fifo_feeder #(
        .DEPTH       (DEPTH),
        .DIV_BITS    (DIV_BITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_part_in  (data_part_in),
        .sel           (sel),
        .pulse_done    (pulse_done),
        .divider       (divider),
        .flush         (flush),
        .clear_flags   (clear_flags),
        .sample_out    (sample_out),
        .sample_update (sample_update),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        pulse_done = 1'b1;
        step();
        pulse_done = 1'b0;
    endtask

    task automatic clr();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    task automatic host_fall(input logic [7:0] lo);
        data_in      = lo;
        data_part_in = 1'b0;
        repeat (5) step();
    endtask

    task automatic host_write(input logic [15:0] w, input logic s);
        sel = s;
        host_fall(w[7:0]);
        data_in      = w[15:8];
        data_part_in = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        rst_n        = 1'b1;
        data_in      = 8'h00;
        data_part_in = 1'b1;
        sel          = 1'b0;
        pulse_done   = 1'b0;
        divider      = '0;
        flush        = 1'b0;
        clear_flags  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_sample_out", 32'(sample_out), 32'h8000);
        chk("rst_update",     32'(sample_update), 32'd0);
        chk("rst_level",      32'(level), 32'd0);
        chk("rst_empty",      32'(empty), 32'd1);
        chk("rst_full",       32'(full), 32'd0);
        chk("rst_overflow",   32'(overflow), 32'd0);
        chk("rst_underflow",  32'(underflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Pulse on empty FIFO
        divider = 8'd0;
        pulse();
        chk("t1_underflow",  32'(underflow), 32'd1);
        chk("t1_sample_out", 32'(sample_out), 32'h8000);
        chk("t1_update",     32'(sample_update), 32'd0);
        clr();
        chk("t1_clear", 32'(underflow), 32'd0);

        // Single write 1234h, capture latency, divider = 2
        sel     = 1'b1;
        divider = 8'd2;
        host_fall(8'h34);
        data_in      = 8'h12;
        data_part_in = 1'b1;
        repeat (3) step();
        chk("t2_level_k2", 32'(level), 32'd0);
        step();
        chk("t2_level_k3", 32'(level), 32'd1);
        repeat (2) step();
        n_upd = 0;
        for (int i = 1; i <= 6; i++) begin
            pulse();
            if (sample_update) n_upd++;
            if (i == 1) begin
                chk("t2_p1_update", 32'(sample_update), 32'd1);
                chk("t2_p1_sample", 32'(sample_out), 32'h1234);
            end
            if (i == 3) chk("t2_p3_underflow", 32'(underflow), 32'd0);
            if (i == 4) chk("t2_p4_underflow", 32'(underflow), 32'd1);
        end
        chk("t2_update_count", 32'(n_upd), 32'd1);
        chk("t2_sample_hold",  32'(sample_out), 32'h1234);

        // Write with sel low is ignored
        host_write(16'hDEAD, 1'b0);
        chk("t2_sel0_level", 32'(level), 32'd0);

        // Nine writes into depth-8 FIFO, then drain
        clr();
        divider = 8'd0;
        for (int i = 1; i <= 9; i++) begin
            host_write(16'(i), 1'b1);
            if (i == 8) begin
                chk("t3_full8",  32'(full), 32'd1);
                chk("t3_level8", 32'(level), 32'd8);
                chk("t3_ovf8",   32'(overflow), 32'd0);
            end
        end
        chk("t3_ovf9",   32'(overflow), 32'd1);
        chk("t3_level9", 32'(level), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            pulse();
            chk($sformatf("t3_pop%0d", i), 32'(sample_out), 32'(i));
        end
        chk("t3_empty", 32'(empty), 32'd1);

        // Full FIFO: push lands together with a pop
        clr();
        for (int i = 0; i < 8; i++) host_write(16'h0011 + 16'(i), 1'b1);
        chk("t4_full", 32'(full), 32'd1);
        host_fall(8'hAA);
        data_in      = 8'hAA;
        data_part_in = 1'b1;
        repeat (3) step();
        pulse_done = 1'b1;
        step();
        pulse_done = 1'b0;
        chk("t4_level",    32'(level), 32'd8);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_update",   32'(sample_update), 32'd1);
        chk("t4_sample",   32'(sample_out), 32'h0011);
        repeat (2) step();
        repeat (8) pulse();
        chk("t4_last_word", 32'(sample_out), 32'hAAAA);
        chk("t4_empty",     32'(empty), 32'd1);

        // Flush together with a push at level 3
        clr();
        divider = 8'd1;
        host_write(16'h0101, 1'b1);
        host_write(16'h0202, 1'b1);
        host_write(16'h0303, 1'b1);
        chk("t5_level3", 32'(level), 32'd3);
        host_fall(8'h44);
        data_in      = 8'h44;
        data_part_in = 1'b1;
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_flush_level",  32'(level), 32'd0);
        chk("t5_flush_sample", 32'(sample_out), 32'hAAAA);
        chk("t5_flush_ovf",    32'(overflow), 32'd0);
        chk("t5_flush_unf",    32'(underflow), 32'd0);
        chk("t5_flush_update", 32'(sample_update), 32'd0);
        repeat (2) step();
        host_write(16'h5555, 1'b1);
        pulse();
        chk("t5_reload_noupd",  32'(sample_update), 32'd0);
        chk("t5_reload_level",  32'(level), 32'd1);
        pulse();
        chk("t5_reload_update", 32'(sample_update), 32'd1);
        chk("t5_reload_sample", 32'(sample_out), 32'h5555);
        divider = 8'd0;
        pulse();
        chk("t5_no_unf", 32'(underflow), 32'd0);
        clear_flags = 1'b1;
        pulse_done  = 1'b1;
        step();
        clear_flags = 1'b0;
        pulse_done  = 1'b0;
        chk("t5_set_wins", 32'(underflow), 32'd1);

        // Reset between the two halves of a host write
        host_write(16'h7777, 1'b1);
        chk("t6_pre_level", 32'(level), 32'd1);
        host_fall(8'h01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sample", 32'(sample_out), 32'h8000);
        chk("t6_rst_level",  32'(level), 32'd0);
        chk("t6_rst_empty",  32'(empty), 32'd1);
        chk("t6_rst_unf",    32'(underflow), 32'd0);
        data_in      = 8'h02;
        data_part_in = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("t6_no_push_level", 32'(level), 32'd0);
        chk("t6_no_push_empty", 32'(empty), 32'd1);
        chk("t6_no_push_ovf",   32'(overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
